// File: rtl/pll_dyn_reconfig_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pll_dyn_reconfig_ctrl
// Purpose  : Run-time reconfiguration sequencer for the rPLL dynamic dividers.
//            It applies divider codes, pulses the PLL reset, waits for the PLL
//            to lock, and qualifies the lock before reporting a stable clock.
//            Lives in the 27 MHz input-clock domain.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clkin        in   1  27 MHz input clock (same net as rPLL CLKIN)
//   rst          in   1  synchronous active-high reset
//   cfg_valid    in   1  new divider codes requested (hold until accepted)
//   cfg_idsel    in   6  IDSEL code, passed to the PLL unmodified
//   cfg_fbdsel   in   6  FBDSEL code
//   cfg_odsel    in   6  ODSEL code
//   cfg_ready    out  1  request can be accepted this cycle
//   pll_lock     in   1  rPLL LOCK, asynchronous to clkin
//   pll_reset    out  1  rPLL RESET
//   pll_idsel    out  6  rPLL IDSEL
//   pll_fbdsel   out  6  rPLL FBDSEL
//   pll_odsel    out  6  rPLL ODSEL
//   locked       out  1  qualified stable lock
//   busy         out  1  reconfiguration sequence in progress
//   fail         out  1  last sequence timed out / lost lock (sticky)
//   relock_cnt   out  8  automatic relock count (only with PLL_RELOCK_EN)
// Build option
//   PLL_RELOCK_EN : lock loss while READY restarts the sequence with the
//                   current codes instead of reporting fail.
// ============================================================================
module pll_dyn_reconfig_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         LOCK_TIMEOUT  = 27000,
    parameter int         STABLE_CYCLES = 256,
    parameter logic [5:0] DEF_IDSEL     = 6'd8,
    parameter logic [5:0] DEF_FBDSEL    = 6'd63,
    parameter logic [5:0] DEF_ODSEL     = 6'd4
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       cfg_valid,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ready,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       busy,
    output logic       fail
`ifdef PLL_RELOCK_EN
    ,
    output logic [7:0] relock_cnt
`endif
);

    localparam int c_max_ab     = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int c_max_cd     = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int c_max_cycles = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    // Terminal values: each phase ends on the cycle its counter hits N-1,
    // so the phase lasts exactly N cycles.
    localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_to_last     = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_ASSERT_RST = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_STABLE     = 3'd3,
        ST_READY      = 3'd4,
        ST_FAIL       = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;        // phase counter (reset/settle/stable)
    logic [c_cnt_w-1:0]   to_cnt_q, to_cnt_d;  // cycles spent in WAIT_LOCK
    logic                 lock_meta_q, lock_s_q;
    logic [5:0]           idsel_q, idsel_d;
    logic [5:0]           fbdsel_q, fbdsel_d;
    logic [5:0]           odsel_q, odsel_d;
    logic                 pll_reset_q, pll_reset_d;
    logic                 locked_q, locked_d;
    logic                 busy_q, busy_d;
    logic                 fail_q, fail_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 accept;
`ifdef PLL_RELOCK_EN
    logic [7:0]           relock_q, relock_d;
`endif

    assign accept = cfg_valid && cfg_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        to_cnt_d = to_cnt_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;
`ifdef PLL_RELOCK_EN
        relock_d = relock_q;
`endif
        case (state_q)
            ST_ASSERT_RST: begin
                if (cnt_q >= c_rst_last) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q >= c_settle_last) begin
                    state_d  = ST_WAIT_LOCK;
                    cnt_d    = '0;
                    to_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (to_cnt_q >= c_to_last) begin
                    state_d = ST_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // A lock glitch restarts qualification but keeps the timeout
                // budget already consumed in WAIT_LOCK.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= c_stable_last) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                // An accepted request takes priority over lock loss.
                if (!accept && !lock_s_q) begin
`ifdef PLL_RELOCK_EN
                    state_d = ST_ASSERT_RST;
                    cnt_d   = '0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
`else
                    state_d = ST_FAIL;
`endif
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_ASSERT_RST;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            state_d  = ST_ASSERT_RST;
            cnt_d    = '0;
            idsel_d  = cfg_idsel;
            fbdsel_d = cfg_fbdsel;
            odsel_d  = cfg_odsel;
        end

        // Outputs are registered from the next state so they align with
        // state_q and cannot glitch on state decode.
        pll_reset_d = (state_d == ST_ASSERT_RST);
        locked_d    = (state_d == ST_READY);
        fail_d      = (state_d == ST_FAIL);
        cfg_ready_d = (state_d == ST_READY) || (state_d == ST_FAIL);
        busy_d      = !cfg_ready_d;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= ST_ASSERT_RST;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            idsel_q     <= DEF_IDSEL;
            fbdsel_q    <= DEF_FBDSEL;
            odsel_q     <= DEF_ODSEL;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
            fail_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
`ifdef PLL_RELOCK_EN
            relock_q    <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            pll_reset_q <= pll_reset_d;
            locked_q    <= locked_d;
            busy_q      <= busy_d;
            fail_q      <= fail_d;
            cfg_ready_q <= cfg_ready_d;
`ifdef PLL_RELOCK_EN
            relock_q    <= relock_d;
`endif
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign locked     = locked_q;
    assign busy       = busy_q;
    assign fail       = fail_q;
`ifdef PLL_RELOCK_EN
    assign relock_cnt = relock_q;
`endif

endmodule
`default_nettype wire
